// File: rtl/noc_axi_wr_arbiter.sv
// Write-channel arbiter: shares one AXI slave AW+W port among NUM_MST masters.
// AW is arbitrated round-robin and held until the slave accepts it. The grant index
// is prepended to AWID so B responses can be routed back. An in-order grant FIFO
// then steers each W burst from the granted master until its WLAST.
module noc_axi_wr_arbiter #(
    parameter int  NUM_MST  = 4,
    parameter int  ADDR_W   = 32,
    parameter int  DATA_W   = 64,
    parameter int  ID_W     = 4,
    parameter int  WQ_DEPTH = 4,
    localparam int IDX_W    = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MST-1:0]          s_aw_valid,
    output logic [NUM_MST-1:0]          s_aw_ready,
    input  logic [NUM_MST*ID_W-1:0]     s_aw_id,
    input  logic [NUM_MST*ADDR_W-1:0]   s_aw_addr,
    input  logic [NUM_MST*8-1:0]        s_aw_len,
    input  logic [NUM_MST-1:0]          s_w_valid,
    output logic [NUM_MST-1:0]          s_w_ready,
    input  logic [NUM_MST*DATA_W-1:0]   s_w_data,
    input  logic [NUM_MST*STRB_W-1:0]   s_w_strb,
    input  logic [NUM_MST-1:0]          s_w_last,
    output logic                        m_aw_valid,
    input  logic                        m_aw_ready,
    output logic [IDX_W+ID_W-1:0]       m_aw_id,
    output logic [ADDR_W-1:0]           m_aw_addr,
    output logic [7:0]                  m_aw_len,
    output logic                        m_w_valid,
    input  logic                        m_w_ready,
    output logic [DATA_W-1:0]           m_w_data,
    output logic [STRB_W-1:0]           m_w_strb,
    output logic                        m_w_last,
    output logic                        wq_full
);

    localparam int PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(WQ_DEPTH + 1);

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand_idx;
    logic [ID_W-1:0]     aw_id_q;
    logic                grant_en;
    logic                aw_hs;

    logic [IDX_W-1:0]    wq_mem [WQ_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count, count_d;
    logic                wq_empty;
    logic                wq_push, wq_pop;
    logic [IDX_W-1:0]    head_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(WQ_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign grant_en = (state_q == IDLE) && (|s_aw_valid) && !wq_full;
    assign aw_hs    = (state_q == LOCK) && m_aw_ready;

    assign m_aw_valid = (state_q == LOCK);
    assign m_aw_id    = {grant_idx, aw_id_q};

    // Round-robin search starting just after rr_ptr; the lowest offset is visited last so it wins.
    // NOTE: every variable written in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_idx  = '0;
        cand_idx = '0;
        for (int k = NUM_MST; k >= 1; k--) begin
            cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_MST);
            if (s_aw_valid[cand_idx]) begin
                win_idx = cand_idx;
            end
        end
    end

    // AW next-state: grab a winner when idle, release on the slave handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_en)   state_d = LOCK;
            LOCK:    if (m_aw_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Forward the slave AWREADY only to the master currently holding the grant.
    always_comb begin
        s_aw_ready = '0;
        if (state_q == LOCK) begin
            s_aw_ready[grant_idx] = m_aw_ready;
        end
    end

    // State register plus the AW fields captured at grant time.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr    <= IDX_W'(NUM_MST - 1);
            grant_idx <= '0;
            aw_id_q   <= '0;
            m_aw_addr <= '0;
            m_aw_len  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                grant_idx <= win_idx;
                aw_id_q   <= s_aw_id[win_idx*ID_W +: ID_W];
                m_aw_addr <= s_aw_addr[win_idx*ADDR_W +: ADDR_W];
                m_aw_len  <= s_aw_len[win_idx*8 +: 8];
            end
            if (aw_hs) begin
                rr_ptr <= grant_idx;
            end
        end
    end

    assign wq_empty = (count == '0);
    assign wq_push  = aw_hs;
    assign wq_pop   = m_w_valid && m_w_ready && m_w_last;

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_d = count;
        if (wq_push && !wq_pop) begin
            count_d = count + 1'b1;
        end else if (!wq_push && wq_pop) begin
            count_d = count - 1'b1;
        end
    end

    // Grant FIFO pointers, occupancy and the registered full flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wq_full <= 1'b0;
        end else begin
            if (wq_push) wr_ptr <= ptr_inc(wr_ptr);
            if (wq_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count   <= count_d;
            wq_full <= (count_d == CNT_W'(WQ_DEPTH));
        end
    end

    // Grant FIFO storage.
    // NOTE: the storage array is not reset; only entries between rd_ptr and wr_ptr are ever read, and the pointers are reset.
    always_ff @(posedge clk) begin
        if (wq_push) begin
            wq_mem[wr_ptr] <= grant_idx;
        end
    end

    // Steer W from the master at the FIFO head; everything is quiet when the FIFO is empty.
    always_comb begin
        head_idx  = wq_empty ? '0 : wq_mem[rd_ptr];
        s_w_ready = '0;
        m_w_valid = 1'b0;
        m_w_data  = '0;
        m_w_strb  = '0;
        m_w_last  = 1'b0;
        if (!wq_empty) begin
            m_w_valid           = s_w_valid[head_idx];
            s_w_ready[head_idx] = m_w_ready;
            m_w_data            = s_w_data[head_idx*DATA_W +: DATA_W];
            m_w_strb            = s_w_strb[head_idx*STRB_W +: STRB_W];
            m_w_last            = s_w_last[head_idx];
        end
    end

endmodule

// File: tb/tb_noc_axi_wr_arbiter.sv
// Directed bench for noc_axi_wr_arbiter: reset, round robin, AW backpressure,
// W ordering through the grant FIFO, FIFO full, and reset in the middle of a burst.
`timescale 1ns/1ps
module tb_noc_axi_wr_arbiter;

    localparam int NUM_MST  = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int ID_W     = 4;
    localparam int WQ_DEPTH = 4;
    localparam int IDX_W    = 2;
    localparam int STRB_W   = DATA_W / 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_MST-1:0]         s_aw_valid;
    logic [NUM_MST-1:0]         s_aw_ready;
    logic [NUM_MST*ID_W-1:0]    s_aw_id;
    logic [NUM_MST*ADDR_W-1:0]  s_aw_addr;
    logic [NUM_MST*8-1:0]       s_aw_len;
    logic [NUM_MST-1:0]         s_w_valid;
    logic [NUM_MST-1:0]         s_w_ready;
    logic [NUM_MST*DATA_W-1:0]  s_w_data;
    logic [NUM_MST*STRB_W-1:0]  s_w_strb;
    logic [NUM_MST-1:0]         s_w_last;
    logic                       m_aw_valid;
    logic                       m_aw_ready;
    logic [IDX_W+ID_W-1:0]      m_aw_id;
    logic [ADDR_W-1:0]          m_aw_addr;
    logic [7:0]                 m_aw_len;
    logic                       m_w_valid;
    logic                       m_w_ready;
    logic [DATA_W-1:0]          m_w_data;
    logic [STRB_W-1:0]          m_w_strb;
    logic                       m_w_last;
    logic                       wq_full;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    noc_axi_wr_arbiter #(
        .NUM_MST  (NUM_MST),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .ID_W     (ID_W),
        .WQ_DEPTH (WQ_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_aw_valid (s_aw_valid),
        .s_aw_ready (s_aw_ready),
        .s_aw_id    (s_aw_id),
        .s_aw_addr  (s_aw_addr),
        .s_aw_len   (s_aw_len),
        .s_w_valid  (s_w_valid),
        .s_w_ready  (s_w_ready),
        .s_w_data   (s_w_data),
        .s_w_strb   (s_w_strb),
        .s_w_last   (s_w_last),
        .m_aw_valid (m_aw_valid),
        .m_aw_ready (m_aw_ready),
        .m_aw_id    (m_aw_id),
        .m_aw_addr  (m_aw_addr),
        .m_aw_len   (m_aw_len),
        .m_w_valid  (m_w_valid),
        .m_w_ready  (m_w_ready),
        .m_w_data   (m_w_data),
        .m_w_strb   (m_w_strb),
        .m_w_last   (m_w_last),
        .wq_full    (wq_full)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [ID_W-1:0] id_of(input int i);
        return ID_W'(i + 5);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int i);
        return ADDR_W'(32'h1000_0000 + i * 256);
    endfunction

    function automatic logic [7:0] len_of(input int i);
        return 8'(i * 2 + 1);
    endfunction

    function automatic logic [DATA_W-1:0] wdata_of(input int i, input int beat);
        return DATA_W'(64'hD000_0000_0000_0000 + i * 64'h100 + beat);
    endfunction

    task automatic set_aw(input int i, input logic v, input logic [7:0] len);
        s_aw_valid[i]                = v;
        s_aw_id[i*ID_W +: ID_W]      = id_of(i);
        s_aw_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
        s_aw_len[i*8 +: 8]           = len;
    endtask

    task automatic set_w(input int i, input logic v, input logic [DATA_W-1:0] d, input logic last);
        s_w_valid[i]                   = v;
        s_w_data[i*DATA_W +: DATA_W]   = d;
        s_w_strb[i*STRB_W +: STRB_W]   = STRB_W'(8'hF0 | i);
        s_w_last[i]                    = last;
    endtask

    task automatic clear_inputs();
        s_aw_valid = '0;
        s_aw_id    = '0;
        s_aw_addr  = '0;
        s_aw_len   = '0;
        s_w_valid  = '0;
        s_w_data   = '0;
        s_w_strb   = '0;
        s_w_last   = '0;
        m_aw_ready = 1'b0;
        m_w_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held for 3 cycles with every master requesting.
        clear_inputs();
        for (int i = 0; i < NUM_MST; i++) set_aw(i, 1'b1, len_of(i));
        rst_n = 1'b0;
        repeat (3) cyc();
        check("rst_aw_valid", m_aw_valid, 0);
        check("rst_s_aw_ready", s_aw_ready, 0);
        check("rst_aw_id", m_aw_id, 0);
        check("rst_aw_addr", m_aw_addr, 0);
        check("rst_aw_len", m_aw_len, 0);
        check("rst_w_valid", m_w_valid, 0);
        check("rst_s_w_ready", s_w_ready, 0);
        check("rst_w_data", m_w_data, 0);
        check("rst_w_strb", m_w_strb, 0);
        check("rst_w_last", m_w_last, 0);
        check("rst_wq_full", wq_full, 0);
        rst_n = 1'b1;
        cyc();
        check("rst_first_valid", m_aw_valid, 1);
        check("rst_first_grant", m_aw_id[ID_W +: IDX_W], 0);

        // Round robin with every master requesting; W drains one single-beat burst per grant.
        m_aw_ready = 1'b1;
        m_w_ready  = 1'b1;
        for (int i = 0; i < NUM_MST; i++) set_w(i, 1'b1, wdata_of(i, 0), 1'b1);
        for (int g = 0; g < 5; g++) begin
            settle();
            check("rr_valid", m_aw_valid, 1);
            check("rr_grant", m_aw_id[ID_W +: IDX_W], exp_order[g]);
            check("rr_id", m_aw_id, {IDX_W'(exp_order[g]), id_of(exp_order[g])});
            check("rr_addr", m_aw_addr, addr_of(exp_order[g]));
            check("rr_s_aw_ready", s_aw_ready, 64'd1 << exp_order[g]);
            cyc();
            check("rr_idle_gap", m_aw_valid, 0);
            cyc();
        end

        // Backpressure on master 1's grant: AW fields hold, no AWREADY leaks.
        m_aw_ready = 1'b0;
        s_w_valid  = '0;
        for (int c = 0; c < 5; c++) begin
            settle();
            check("bp_valid", m_aw_valid, 1);
            check("bp_id", m_aw_id, {IDX_W'(1), id_of(1)});
            check("bp_addr", m_aw_addr, addr_of(1));
            check("bp_len", m_aw_len, len_of(1));
            check("bp_s_aw_ready", s_aw_ready, 0);
            cyc();
        end
        m_aw_ready = 1'b1;
        settle();
        check("bp_release_ready", s_aw_ready, 4'b0010);
        check("bp_release_valid", m_aw_valid, 1);
        cyc();
        check("bp_after_hs", m_aw_valid, 0);

        // W ordering: master 2 (len 3) granted before master 0 (len 0).
        do_reset();
        m_aw_ready = 1'b1;
        m_w_ready  = 1'b1;
        set_aw(2, 1'b1, 8'd3);
        set_w(0, 1'b1, wdata_of(0, 0), 1'b1);
        set_w(2, 1'b1, wdata_of(2, 0), 1'b0);
        cyc();
        check("wo_grant2", m_aw_id[ID_W +: IDX_W], 2);
        check("wo_len2", m_aw_len, 3);
        check("wo_empty_valid", m_w_valid, 0);
        check("wo_empty_ready", s_w_ready, 0);
        cyc();
        set_aw(2, 1'b0, 8'd3);
        set_aw(0, 1'b1, 8'd0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) set_aw(0, 1'b0, 8'd0);
            set_w(2, 1'b1, wdata_of(2, k), (k == 3));
            settle();
            check("wo_m2_valid", m_w_valid, 1);
            check("wo_m2_data", m_w_data, wdata_of(2, k));
            check("wo_m2_ready", s_w_ready, 4'b0100);
            check("wo_m2_last", m_w_last, (k == 3) ? 1 : 0);
            cyc();
        end
        set_w(2, 1'b0, '0, 1'b0);
        settle();
        check("wo_m0_valid", m_w_valid, 1);
        check("wo_m0_data", m_w_data, wdata_of(0, 0));
        check("wo_m0_strb", m_w_strb, 8'hF0);
        check("wo_m0_ready", s_w_ready, 4'b0001);
        check("wo_m0_last", m_w_last, 1);
        cyc();
        set_w(0, 1'b0, '0, 1'b0);
        settle();
        check("wo_drained_valid", m_w_valid, 0);
        check("wo_drained_ready", s_w_ready, 0);

        // FIFO full: four grants with W stalled, fifth request blocked until a pop.
        do_reset();
        m_aw_ready = 1'b1;
        m_w_ready  = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            set_aw(i, 1'b1, len_of(i));
            set_w(i, 1'b1, wdata_of(i, 0), 1'b1);
        end
        repeat (8) cyc();
        check("full_flag", wq_full, 1);
        check("full_no_grant", m_aw_valid, 0);
        cyc();
        check("full_still_blocked", m_aw_valid, 0);
        check("full_still_flag", wq_full, 1);
        check("full_head_data", m_w_data, wdata_of(0, 0));
        m_w_ready = 1'b1;
        settle();
        check("full_pop_ready", s_w_ready, 4'b0001);
        cyc();
        m_w_ready = 1'b0;
        settle();
        check("full_cleared", wq_full, 0);
        check("full_grant_not_yet", m_aw_valid, 0);
        cyc();
        check("full_next_grant", m_aw_valid, 1);
        check("full_next_idx", m_aw_id[ID_W +: IDX_W], 0);
        check("full_new_head", m_w_data, wdata_of(1, 0));

        // Reset on beat 2 of a len=7 burst from master 1.
        do_reset();
        m_aw_ready = 1'b1;
        m_w_ready  = 1'b1;
        set_aw(1, 1'b1, 8'd7);
        set_w(1, 1'b1, wdata_of(1, 0), 1'b0);
        cyc();
        cyc();
        set_aw(1, 1'b0, 8'd7);
        settle();
        check("mb_beat0_valid", m_w_valid, 1);
        cyc();
        set_w(1, 1'b1, wdata_of(1, 1), 1'b0);
        cyc();
        set_w(1, 1'b1, wdata_of(1, 2), 1'b0);
        settle();
        check("mb_beat2_valid", m_w_valid, 1);
        check("mb_beat2_ready", s_w_ready, 4'b0010);
        rst_n = 1'b0;
        cyc();
        check("mb_rst_w_valid", m_w_valid, 0);
        check("mb_rst_s_w_ready", s_w_ready, 0);
        check("mb_rst_w_data", m_w_data, 0);
        check("mb_rst_aw_valid", m_aw_valid, 0);
        check("mb_rst_full", wq_full, 0);
        rst_n = 1'b1;
        cyc();
        check("mb_post_w_valid", m_w_valid, 0);
        check("mb_post_aw_valid", m_aw_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
